clk_div_sched: RTL

- Programmable clock-divider controller for the testbench clocking infrastructure.
- Derives a divided clock from the single fast `clk`, for example 100 MHz to 50/25/10 MHz.
- Accepts new divisor settings over a valid/ready handshake and switches only at period boundaries, so no runt pulses are produced.
- Emits a one-cycle `tick` strobe on each rising edge of the divided clock, for use by downstream schedulers.

---
 rtl/clk_div_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - programmable clock divider with boundary-safe divisor switching
//
// Purpose: derives a divided clock (o_clk_out) from i_clk. The high and low phases each
// last D = o_div_active cycles of i_clk. A new divisor can be offered over a valid/ready
// handshake at any time, but it only takes effect at a high-to-low boundary. Because of
// that, no phase is ever a mix of two divisors. Stopping also waits for a low boundary.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          run request (1 = generate o_clk_out, 0 = stop cleanly)
//   i_cfg_valid   new divisor offered
//   i_cfg_div     requested half-period in i_clk cycles (0 is treated as 1)
//   o_cfg_ready   divisor can be accepted this cycle
//   o_clk_out     divided clock, driven straight from a flop
//   o_tick        one-cycle strobe in the first cycle o_clk_out is high
//   o_div_active  half-period currently in force
//   o_busy        controller is not idle
module clk_div_sched #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    input  logic [CNT_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_div_active,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PEND  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_div_pend;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_pend_nxt;

    logic             w_hs;
    logic             w_last;
    logic [CNT_W-1:0] w_cfg_val;

    assign o_cfg_ready  = (r_state == IDLE) || (r_state == RUN);
    assign o_busy       = (r_state != IDLE);
    assign o_clk_out    = r_clk_out;
    assign o_tick       = r_tick;
    assign o_div_active = r_div_active;

    assign w_hs      = i_cfg_valid && o_cfg_ready;
    assign w_cfg_val = (i_cfg_div == '0) ? CNT_W'(1) : i_cfg_div;
    // r_div_active is never 0, so D-1 cannot underflow and the counter never passes it
    assign w_last    = (r_cnt == r_div_active - CNT_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clk_nxt   = r_clk_out;
        w_tick_nxt  = 1'b0;
        w_div_nxt   = r_div_active;
        w_pend_nxt  = r_div_pend;

        // Common phase counter for every non-idle state
        if (r_state != IDLE) begin
            if (w_last) begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = ~r_clk_out;
                w_tick_nxt = ~r_clk_out;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (w_hs) begin
                    w_div_nxt = w_cfg_val;
                end
                if (i_en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_hs) begin
                    w_pend_nxt  = w_cfg_val;
                    w_state_nxt = PEND;
                end else if (!i_en) begin
                    if (!r_clk_out) begin
                        // Already low: stop now and suppress any rise due this edge
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_clk_nxt   = 1'b0;
                        w_tick_nxt  = 1'b0;
                    end else if (w_last) begin
                        // High phase ends on this very edge, so no drain is needed
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            PEND: begin
                if (w_last && r_clk_out) begin
                    w_div_nxt   = r_div_pend;
                    w_state_nxt = i_en ? RUN : IDLE;
                end
            end
            DRAIN: begin
                if (w_last && r_clk_out) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_div_active <= CNT_W'(DEFAULT_DIV);
            r_div_pend   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_clk_out    <= w_clk_nxt;
            r_tick       <= w_tick_nxt;
            r_div_active <= w_div_nxt;
            r_div_pend   <= w_pend_nxt;
        end
    end

endmodule
